// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and an out-of-order long-latency unit. Long results are queued
//   in a small FIFO and drained whenever the pipeline does not need the port.
//   A 32-bit scoreboard of outstanding long destinations drives Stall to
//   decode on RAW/WAW hazards.
//
//   Optional feature: define REGFILE_CLEAR_EN to zero-fill r0..r31 after reset
//   (32 cycles, Busy/Stall held high, all inputs ignored).
//
// Ports
//   CLK, Resetn                 clock, asynchronous active-low reset
//   PipeWr/PipeRw/PipeBusW      pipeline writeback request
//   LongValid/LongRw/LongBusW   long-unit result; LongReady = FIFO can accept
//   Ra, Rb, DecRd, DecRdValid   decode operands / destination
//   IssueLong                   decode issues a long op to DecRd
//   Stall, Busy                 hold decode / clear sequence running
//   RegWr, Rw, busW             register file write port
module regfile_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              CLK,
    input  logic              Resetn,
    input  logic              PipeWr,
    input  logic [4:0]        PipeRw,
    input  logic [DATA_W-1:0] PipeBusW,
    input  logic              LongValid,
    output logic              LongReady,
    input  logic [4:0]        LongRw,
    input  logic [DATA_W-1:0] LongBusW,
    input  logic [4:0]        Ra,
    input  logic [4:0]        Rb,
    input  logic [4:0]        DecRd,
    input  logic              DecRdValid,
    input  logic              IssueLong,
    output logic              Stall,
    output logic              Busy,
    output logic              RegWr,
    output logic [4:0]        Rw,
    output logic [DATA_W-1:0] busW
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [4:0]        fifo_rw_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       pending_q, pending_d;

    logic       run;
    logic [4:0] clr_idx;
    logic       full, empty;
    logic       pipe_win, pop, push, issue;

`ifdef REGFILE_CLEAR_EN
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic       state_q, state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 5'd1;
            if (clr_cnt_q == 5'd31) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign run     = (state_q == ST_RUN);
    assign clr_idx = clr_cnt_q;
`else
    assign run     = 1'b1;
    assign clr_idx = '0;
`endif

    assign Busy  = ~run;
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // Resetn gates the handshake so LongReady reads 0 while reset is held.
    assign LongReady = Resetn & run & ~full;

    // Pipeline write to r0 does not claim the port, letting the FIFO drain.
    assign pipe_win = PipeWr & (PipeRw != 5'd0);
    assign pop      = run & ~pipe_win & ~empty;
    // A long result to r0 completes the handshake but is never stored.
    assign push     = LongValid & LongReady & (LongRw != 5'd0);

    assign Stall = Busy | pending_q[Ra] | pending_q[Rb] |
                   (DecRdValid & pending_q[DecRd]);
    assign issue = IssueLong & ~Stall & (DecRd != 5'd0);

    always_comb begin
        RegWr = 1'b0;
        Rw    = '0;
        busW  = '0;
        if (!Resetn) begin
            RegWr = 1'b0;
        end else if (!run) begin
            RegWr = 1'b1;
            Rw    = clr_idx;
        end else if (pipe_win) begin
            RegWr = 1'b1;
            Rw    = PipeRw;
            busW  = PipeBusW;
        end else if (!empty) begin
            RegWr = 1'b1;
            Rw    = fifo_rw_q[rd_ptr_q];
            busW  = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Issue requires the destination not pending, so set and clear of the
    // same bit cannot coincide; the order below is therefore immaterial.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[fifo_rw_q[rd_ptr_q]] = 1'b0;
        end
        if (issue) begin
            pending_d[DecRd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rw_q[wr_ptr_q]   <= LongRw;
            fifo_data_q[wr_ptr_q] <= LongBusW;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int unsigned DEPTH = 2;
`ifdef REGFILE_CLEAR_EN
    localparam logic CLR = 1'b1;
`else
    localparam logic CLR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Resetn = 1'b0;
    logic        PipeWr, LongValid, DecRdValid, IssueLong;
    logic [4:0]  PipeRw, LongRw, Ra, Rb, DecRd;
    logic [31:0] PipeBusW, LongBusW;
    logic        LongReady, Stall, Busy, RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
        .CLK(CLK), .Resetn(Resetn),
        .PipeWr(PipeWr), .PipeRw(PipeRw), .PipeBusW(PipeBusW),
        .LongValid(LongValid), .LongReady(LongReady), .LongRw(LongRw), .LongBusW(LongBusW),
        .Ra(Ra), .Rb(Rb), .DecRd(DecRd), .DecRdValid(DecRdValid), .IssueLong(IssueLong),
        .Stall(Stall), .Busy(Busy), .RegWr(RegWr), .Rw(Rw), .busW(busW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pw;
        logic [4:0]  prw;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrw;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic [4:0]  drd;
        logic        drv;
        logic        iss;
        logic        ewr;
        logic [4:0]  erw;
        logic [31:0] ebus;
        logic        erdy;
        logic        estall;
    } vec_t;

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] d;
    } ent_t;

    vec_t tbl[$];
    vec_t rst_seq[$];

    // Reference model: queue of long results, pending flags per register,
    // and the list of issued destinations whose result has not yet arrived.
    ent_t        mq[$];
    bit          mpend[32];
    logic [4:0]  outs[$];

    function automatic vec_t mk(input logic pw, input logic [4:0] prw, input logic [31:0] pd,
                                input logic lv, input logic [4:0] lrw, input logic [31:0] ld,
                                input logic [4:0] ra, input logic [4:0] drd, input logic drv,
                                input logic iss, input logic ewr, input logic [4:0] erw,
                                input logic [31:0] ebus, input logic erdy, input logic estall);
        vec_t v;
        v.pw = pw; v.prw = prw; v.pd = pd; v.lv = lv; v.lrw = lrw; v.ld = ld;
        v.ra = ra; v.drd = drd; v.drv = drv; v.iss = iss;
        v.ewr = ewr; v.erw = erw; v.ebus = ebus; v.erdy = erdy; v.estall = estall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ewr, input logic [4:0] erw,
                            input logic [31:0] ebus, input logic erdy, input logic estall,
                            input logic ebusy);
        chk({tag, ".RegWr"}, 64'(RegWr), 64'(ewr));
        chk({tag, ".Rw"}, 64'(Rw), 64'(erw));
        chk({tag, ".busW"}, 64'(busW), 64'(ebus));
        chk({tag, ".LongReady"}, 64'(LongReady), 64'(erdy));
        chk({tag, ".Stall"}, 64'(Stall), 64'(estall));
        chk({tag, ".Busy"}, 64'(Busy), 64'(ebusy));
    endtask

    task automatic drive_idle();
        PipeWr = 0; PipeRw = 0; PipeBusW = 0;
        LongValid = 0; LongRw = 0; LongBusW = 0;
        Ra = 0; Rb = 0; DecRd = 0; DecRdValid = 0; IssueLong = 0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge CLK);
        PipeWr = v.pw; PipeRw = v.prw; PipeBusW = v.pd;
        LongValid = v.lv; LongRw = v.lrw; LongBusW = v.ld;
        Ra = v.ra; Rb = 0; DecRd = v.drd; DecRdValid = v.drv; IssueLong = v.iss;
        #1;
        chk_outs(tag, v.ewr, v.erw, v.ebus, v.erdy, v.estall, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        Resetn = 1'b1;
`ifdef REGFILE_CLEAR_EN
        // Activity during the clear sequence must be ignored.
        PipeWr = 1; PipeRw = 3; PipeBusW = 32'h5555;
        LongValid = 1; LongRw = 5; LongBusW = 32'h6666;
        IssueLong = 1; DecRd = 6; DecRdValid = 1;
        for (int k = 0; k < 32; k++) begin
            #1;
            chk_outs("clear", 1'b1, 5'(k), 32'h0, 1'b0, 1'b1, 1'b1);
            @(negedge CLK);
        end
        drive_idle();
        #1;
        chk_outs("clear_done", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
`else
        drive_idle();
        #1;
        chk_outs("run_at_release", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
`endif
    endtask

    task automatic rand_cycle(input int unsigned n);
        logic        pw, lv, drv, iss, has_idx;
        logic [4:0]  prw, lrw, ra, rb, drd;
        logic [31:0] pd, ld;
        int unsigned idx;
        logic        erdy, estall, ewr;
        logic [4:0]  erw;
        logic [31:0] ebus;
        ent_t        e;

        pw  = ($urandom_range(0, 2) == 0);
        prw = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        pd  = $urandom;
        iss = ($urandom_range(0, 3) == 0);
        drd = 5'($urandom_range(0, 31));
        drv = iss ? 1'b1 : 1'($urandom_range(0, 1));
        ra  = 5'($urandom_range(0, 31));
        rb  = 5'($urandom_range(0, 31));
        if (outs.size() > 0 && $urandom_range(0, 2) == 0)
            ra = outs[$urandom_range(0, outs.size() - 1)];
        ld = $urandom;
        has_idx = 0; idx = 0;
        if (outs.size() > 0 && $urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, outs.size() - 1);
            lv = 1; lrw = outs[idx]; has_idx = 1;
        end else if ($urandom_range(0, 9) == 0) begin
            lv = 1; lrw = 5'd0;
        end else begin
            lv = 0; lrw = 5'($urandom_range(0, 31));
        end

        @(negedge CLK);
        PipeWr = pw; PipeRw = prw; PipeBusW = pd;
        LongValid = lv; LongRw = lrw; LongBusW = ld;
        Ra = ra; Rb = rb; DecRd = drd; DecRdValid = drv; IssueLong = iss;
        #1;

        estall = mpend[ra] || mpend[rb] || (drv && mpend[drd]);
        erdy   = (mq.size() < DEPTH);
        ewr = 0; erw = 0; ebus = 0;
        if (pw && prw != 0) begin
            ewr = 1; erw = prw; ebus = pd;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            ewr = 1; erw = e.rw; ebus = e.d;
            mpend[e.rw] = 0;
        end
        if (lv && erdy) begin
            if (lrw != 0) begin
                e.rw = lrw; e.d = ld;
                mq.push_back(e);
            end
            if (has_idx) outs.delete(idx);
        end
        if (iss && !estall && drd != 0) begin
            mpend[drd] = 1;
            outs.push_back(drd);
        end
        chk_outs($sformatf("rand%0d", n), ewr, erw, ebus, erdy, estall, 1'b0);
    endtask

    initial begin
        drive_idle();
        Resetn = 1'b0;

        // Reset values, with a pipeline request that must not reach the port.
        @(negedge CLK);
        PipeWr = 1; PipeRw = 3; PipeBusW = 32'h1234;
        #1;
        chk_outs("reset", 1'b0, 5'd0, 32'h0, 1'b0, CLR, CLR);
        release_reset();

        tbl.push_back(mk(0,0,0,            0,0,0,             0,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             0,5,1,1, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             5,0,0,0, 0,0,0,            1,1));
        tbl.push_back(mk(0,0,0,            1,5,32'hDEADBEEF,  5,0,0,0, 0,0,0,            1,1));
        tbl.push_back(mk(0,0,0,            0,0,0,             5,0,0,0, 1,5,32'hDEADBEEF, 1,1));
        tbl.push_back(mk(0,0,0,            0,0,0,             5,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             0,7,1,1, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            1,7,32'h22,        0,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(1,3,32'h11,       0,0,0,             0,0,0,0, 1,3,32'h11,       1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             0,0,0,0, 1,7,32'h22,       1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             0,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(1,1,32'hA1,       0,0,0,             0,8,1,1, 1,1,32'hA1,       1,0));
        tbl.push_back(mk(1,1,32'hA2,       1,8,32'h88,        0,9,1,1, 1,1,32'hA2,       1,0));
        tbl.push_back(mk(1,2,32'hA3,       1,9,32'h99,        0,0,0,0, 1,2,32'hA3,       1,0));
        tbl.push_back(mk(1,2,32'hA4,       1,10,32'h1010,     8,0,0,0, 1,2,32'hA4,       0,1));
        tbl.push_back(mk(0,0,0,            0,0,0,             8,0,0,0, 1,8,32'h88,       0,1));
        tbl.push_back(mk(0,0,0,            0,0,0,             8,0,0,0, 1,9,32'h99,       1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             0,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            1,0,32'hBAD,       0,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             0,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            0,0,0,             0,4,1,1, 0,0,0,            1,0));
        tbl.push_back(mk(0,0,0,            1,4,32'h44,        0,0,0,0, 0,0,0,            1,0));
        tbl.push_back(mk(1,0,32'hFFFF,     0,0,0,             4,0,0,0, 1,4,32'h44,       1,1));
        tbl.push_back(mk(0,0,0,            0,0,0,             4,0,0,0, 0,0,0,            1,0));
        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

        // Reset mid-operation: r9 pending, r10/r11 queued behind pipeline writes.
        rst_seq.push_back(mk(0,0,0, 0,0,0,         0,9,1,1,  0,0,0, 1,0));
        rst_seq.push_back(mk(0,0,0, 0,0,0,         0,10,1,1, 0,0,0, 1,0));
        rst_seq.push_back(mk(0,0,0, 0,0,0,         0,11,1,1, 0,0,0, 1,0));
        rst_seq.push_back(mk(1,1,1, 1,10,32'hA0,   0,0,0,0,  1,1,1, 1,0));
        rst_seq.push_back(mk(1,1,2, 1,11,32'hB0,   0,0,0,0,  1,1,2, 1,0));
        rst_seq.push_back(mk(1,2,3, 0,0,0,         9,0,0,0,  1,2,3, 0,1));
        foreach (rst_seq[i]) apply($sformatf("pre_rst%0d", i), rst_seq[i]);
        #2;
        Resetn = 1'b0;
        #1;
        chk_outs("mid_reset", 1'b0, 5'd0, 32'h0, 1'b0, CLR, CLR);
        @(posedge CLK);
        release_reset();
        apply("post_rst0", mk(0,0,0, 0,0,0, 9,0,0,0, 0,0,0, 1,0));
        apply("post_rst1", mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 1,0));
        apply("post_rst2", mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 1,0));

        // Design is now empty with no pending bits: model starts from the same point.
        for (int i = 0; i < 32; i++) mpend[i] = 0;
        for (int n = 0; n < 3000; n++) rand_cycle(n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32x32 register file in the pipelined CPU. It shares the file's single write port between the in-order pipeline writeback and a long-latency unit (mult/div, slow load) that finishes out of order. It buffers long-latency results in a small FIFO and keeps a scoreboard of pending destinations, raising `Stall` to decode on RAW and WAW hazards. It can optionally sequence a zero-fill of all registers after reset.

## Interface
- `FIFO_DEPTH`, 2, long-result buffer entries; power of two, at least 2.
- `DATA_W`, 32, data width.
- `CLK`  in  1  clock; all state changes on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `PipeWr`  in  1  pipeline WB write request.
- `PipeRw`  in  5  pipeline WB destination.
- `PipeBusW`  in  DATA_W  pipeline WB data.
- `LongValid`  in  1  long unit result valid.
- `LongReady`  out  1  FIFO can accept a result.
- `LongRw`  in  5  long result destination.
- `LongBusW`  in  DATA_W  long result data.
- `Ra`, `Rb`  in  5 each  decode source registers.
- `DecRd`  in  5  decode destination register.
- `DecRdValid`  in  1  `DecRd` is meaningful.
- `IssueLong`  in  1  decode issues a long op targeting `DecRd`.
- `Stall`  out  1  hold decode this cycle.
- `Busy`  out  1  clear sequence in progress.
- `RegWr`  out  1  register file write enable.
- `Rw`  out  5  register file write address.
- `busW`  out  DATA_W  register file write data.

## Operation
- States: CLEAR (exists only with the macro) and RUN. Reset enters CLEAR if the macro is defined, otherwise RUN.
- Write port in RUN, evaluated combinationally each cycle:
  - If `PipeWr`=1 and `PipeRw`!=0, the pipeline wins: `RegWr`=1, `Rw`=`PipeRw`, `busW`=`PipeBusW`.
  - Otherwise, if the FIFO is non-empty, the head drains: `RegWr`=1, `Rw`/`busW` come from the head, and the head pops on the edge.
  - Otherwise `RegWr`=0, `Rw`=0, `busW`=0.
- Writes targeting r0:
  - A pipeline write to r0 is dropped and does not block draining.
  - A long result to r0 is accepted and discarded; it never enters the FIFO.
- FIFO handshake:
  - `LongReady` = RUN and not full. It depends only on state, never on `LongValid`.
  - Push occurs on an edge where `LongValid` and `LongReady` are both 1.
  - Push and pop in the same cycle are both performed.
  - Read and write pointers wrap modulo `FIFO_DEPTH`. An occupancy counter of log2(`FIFO_DEPTH`)+1 bits distinguishes full from empty.
- Scoreboard (32-bit `pending` vector, bit 0 always 0):
  - The bit is set on the edge where `IssueLong`=1, `Stall`=0 and `DecRd`!=0.
  - The bit is cleared on the edge where the FIFO head carrying that register is written.
  - A long result arriving on the same edge as its own issue is illegal.
- `Stall` = `Busy` OR `pending[Ra]` OR `pending[Rb]` OR (`DecRdValid` AND `pending[DecRd]`).
  - `IssueLong` is ignored while `Stall`=1.
  - Set and clear of the same bit can therefore never coincide.
- Drain starvation is not guarded. Back-to-back pipeline writes delay the drain, and decode eventually stalls on the pending register.

## Timing
- Reset values:
  - `RegWr`=0, `Rw`=0, `busW`=0, `LongReady`=0, FIFO empty, `pending`=0.
  - `Busy`=`Stall`=1 with the macro; 0 without it.
- While `Resetn`=0, `RegWr` is forced to 0 regardless of `PipeWr`.
- Pipeline write latency: 0 cycles; passes through in the request cycle.
- Long result latency: accepted at edge N; written no earlier than cycle N+1; pending bit clears at that write's edge.
- Full FIFO: `LongReady` returns to 1 the cycle after a pop.
- Reset asserted mid-operation: FIFO contents and pending bits are lost immediately. The clear sequence restarts from r0.

## Configuration
- `REGFILE_CLEAR_EN` defined:
  - After `Resetn` rises, CLEAR drives `RegWr`=1, `Rw`=count, `busW`=0 for count 0..31, r0 included: 32 cycles.
  - `Busy`=`Stall`=1 and `LongReady`=0 throughout CLEAR. Pipeline and long inputs are ignored.
  - After the count-31 edge the block enters RUN. `Busy` falls in the 33rd cycle after reset release.
- `REGFILE_CLEAR_EN` undefined: no CLEAR state or counter; `Busy` is tied 0; the block enters RUN directly out of reset.

## Test plan
- Reset release with macro → 32 writes of 0 to r0..r31 in order. `Busy`=1 for 32 cycles, then 0, `LongReady`=1. Without macro: `Busy`=0 immediately.
- `IssueLong` with `DecRd`=5, then `Ra`=5 → `Stall`=1. Later a long result (r5, 0xDEADBEEF) arrives with `PipeWr`=0 → written the next cycle; `Stall` drops the cycle after the write.
- Pipeline write (r3, 0x11) in the same cycle the FIFO head (r7, 0x22) is ready → r3 written first, r7 written the following cycle.
- `FIFO_DEPTH`=2 with `PipeWr` held 1 → two pushes accepted, `LongReady`=0. Drop `PipeWr` → entries drain in order, and `LongReady` rises after the first pop.
- Long result to r0 → no write and no FIFO entry. Pipeline write to r0 with a non-empty FIFO → the FIFO head drains that cycle.
- Assert `Resetn`=0 with 2 entries queued and bit r9 pending → `RegWr`=0 at once. After release, FIFO is empty and `Stall` with `Ra`=9 is 0 (without macro).
